// File: rtl/alu_arbiter_if.sv
// Handshake bundle between two ALU requesters, the arbiter and the result consumer.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif
`ifndef ALUCTRL_LEN
`define ALUCTRL_LEN 4
`endif

interface alu_arbiter_if #(
    parameter int W = `WORD_LEN,
    parameter int C = `ALUCTRL_LEN
);
    logic         req0_valid;
    logic         req1_valid;
    logic         req0_ready;
    logic         req1_ready;
    logic [W-1:0] req0_op1;
    logic [W-1:0] req0_op2;
    logic [W-1:0] req1_op1;
    logic [W-1:0] req1_op2;
    logic [C-1:0] req0_ctrl;
    logic [C-1:0] req1_ctrl;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_res;
    logic         rsp_z;

    modport master (
        output req0_valid, req1_valid,
        output req0_op1, req0_op2, req1_op1, req1_op2,
        output req0_ctrl, req1_ctrl, rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_res, rsp_z
    );

    modport slave (
        input  req0_valid, req1_valid,
        input  req0_op1, req0_op2, req1_op1, req1_op2,
        input  req0_ctrl, req1_ctrl, rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_res, rsp_z
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU through an IDLE/EXEC/RESP sequencer.
// Define ALU_ARB_RR_EN for round-robin grant; otherwise requester 0 has priority.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif
`ifndef ALUCTRL_LEN
`define ALUCTRL_LEN 4
`endif
`ifndef ADD
`define ADD  4'd0
`endif
`ifndef SUB
`define SUB  4'd1
`endif
`ifndef ADDU
`define ADDU 4'd2
`endif
`ifndef AND
`define AND  4'd3
`endif
`ifndef OR
`define OR   4'd4
`endif
`ifndef SLT
`define SLT  4'd5
`endif

module alu_arbiter #(
    parameter int W = `WORD_LEN,
    parameter int C = `ALUCTRL_LEN
) (
    input  logic clk,
    input  logic rst,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t       state_q;
    logic [W-1:0] op1_q;
    logic [W-1:0] op2_q;
    logic [C-1:0] ctrl_q;
    logic         id_q;
    logic         rsp_valid_q;
    logic         rsp_id_q;
    logic         rsp_z_q;
    logic [W-1:0] rsp_res_q;

    logic         gnt0;
    logic         gnt1;
    logic         accept;
    logic [W-1:0] alu_res_d;
    logic         slt;

`ifdef ALU_ARB_RR_EN
    logic last_q;

    // On contention the requester that did not win last time goes first.
    always_comb begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            gnt0 = last_q;
            gnt1 = !last_q;
        end
    end
`else
    assign gnt0 = bus.req0_valid;
    assign gnt1 = bus.req1_valid && !bus.req0_valid;
`endif

    assign accept         = (state_q == IDLE) && !rst && (gnt0 || gnt1);
    assign bus.req0_ready = (state_q == IDLE) && !rst && gnt0;
    assign bus.req1_ready = (state_q == IDLE) && !rst && gnt1;

    assign slt = $signed(op1_q) < $signed(op2_q);

    always_comb begin
        alu_res_d = '0;
        case (ctrl_q)
            `ADD:    alu_res_d = op1_q + op2_q;
            `SUB:    alu_res_d = op1_q - op2_q;
            `ADDU:   alu_res_d = op1_q + op2_q;
            `AND:    alu_res_d = op1_q & op2_q;
            `OR:     alu_res_d = op1_q | op2_q;
            `SLT:    alu_res_d = {{(W-1){1'b0}}, slt};
            default: alu_res_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op1_q       <= '0;
            op2_q       <= '0;
            ctrl_q      <= '0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_z_q     <= 1'b0;
            rsp_res_q   <= '0;
`ifdef ALU_ARB_RR_EN
            last_q      <= 1'b1;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        op1_q   <= gnt1 ? bus.req1_op1 : bus.req0_op1;
                        op2_q   <= gnt1 ? bus.req1_op2 : bus.req0_op2;
                        ctrl_q  <= gnt1 ? bus.req1_ctrl : bus.req0_ctrl;
                        id_q    <= gnt1;
                        state_q <= EXEC;
`ifdef ALU_ARB_RR_EN
                        last_q  <= gnt1;
`endif
                    end
                end
                EXEC: begin
                    rsp_res_q   <= alu_res_d;
                    rsp_z_q     <= (op1_q == op2_q);
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_res   = rsp_res_q;
    assign bus.rsp_z     = rsp_z_q;
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter W, default `WORD_LEN (32), operand/result width.
REQ-002 SHALL have parameter C, default `ALUCTRL_LEN, ALU control code width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1  requester n has an operation pending.
REQ-006 SHALL have ports req0_ready / req1_ready  output  1  operation from requester n accepted this cycle.
REQ-007 SHALL have ports req0_op1, req0_op2, req1_op1, req1_op2  input  W  operands.
REQ-008 SHALL have ports req0_ctrl / req1_ctrl  input  C  ALU control code (`ADD, `SUB, `ADDU, `AND, `OR, `SLT).
REQ-009 SHALL have port rsp_valid  output  1  result available.
REQ-010 SHALL have port rsp_ready  input  1  consumer takes result.
REQ-011 SHALL have port rsp_id  output  1  requester owning current result.
REQ-012 SHALL have port rsp_res  output  W  registered ALU result.
REQ-013 SHALL have port rsp_z  output  1  registered equality flag (op1 == op2).

Function
REQ-014 SHALL contain one FSM with states IDLE, EXEC, RESP; exactly one ALU instance shared by both requesters.
REQ-015 IDLE: if any reqN_valid, SHALL select one grant, assert only that reqN_ready (combinational, IDLE only), latch op1/op2/ctrl/id, go to EXEC; else stay IDLE.
REQ-016 reqN_ready SHALL be 0 in EXEC and RESP and for the non-granted requester.
REQ-017 EXEC: SHALL drive ALU from latched operands, register result/z into rsp_res/rsp_z, go to RESP; lasts exactly one cycle.
REQ-018 RESP: SHALL hold rsp_valid=1 with rsp_res, rsp_z, rsp_id stable until rsp_ready=1; on rsp_valid&rsp_ready go to IDLE.
REQ-019 Latency: acceptance edge at cycle N -> rsp_valid high from cycle N+2; min issue interval 3 cycles (no accept in the RESP->IDLE handoff cycle).
REQ-020 Arithmetic: `ADD/`SUB signed two's-complement, wrap modulo 2^W, no overflow flag; `ADDU unsigned wrap; `SLT signed compare, result 1 or 0 zero-extended to W.
REQ-021 Unlisted control codes SHALL produce rsp_res=0; rsp_z still equality of operands.
REQ-022 Operand changes on reqN_* after acceptance SHALL NOT affect the in-flight result.
REQ-023 Requester deasserting valid before ready SHALL NOT be granted; no operation issued for it.

Reset
REQ-024 rst=1 at a clock edge SHALL force IDLE, rsp_valid=0, rsp_id=0, rsp_res=0, rsp_z=0, last-grant pointer=1.
REQ-025 rst asserted in EXEC or RESP SHALL discard the in-flight operation without asserting rsp_valid.
REQ-026 While rst=1, req0_ready and req1_ready SHALL be 0.

Configuration
REQ-027 Macro ALU_ARB_RR_EN defined: round-robin; when both valid in IDLE, grant requester not last granted; pointer updates to granted id on each grant; single valid requester always granted.
REQ-028 ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins on simultaneous requests; pointer logic absent.

Verification
REQ-029 After reset, req0 ADD 5,7 alone -> req0_ready pulse 1 cycle, rsp_valid at +2 cycles, rsp_res=12, rsp_z=0, rsp_id=0.
REQ-030 req1 SUB 3,3 -> rsp_res=0, rsp_z=1, rsp_id=1; SLT 0xFFFFFFFF,1 -> rsp_res=1; ADDU 0xFFFFFFFF,1 -> rsp_res=0.
REQ-031 Both valid continuously, 4 ops, RR_EN defined -> grant order 0,1,0,1; undefined -> 0,0,0,0.
REQ-032 rsp_ready held 0 for 5 cycles in RESP -> rsp_res/rsp_z/rsp_id stable, both reqN_ready=0; release -> IDLE next cycle.
REQ-033 rst pulsed in EXEC after acceptance -> rsp_valid never asserts, outputs zero, next simultaneous request granted to requester 0.
REQ-034 Change req0_op1 the cycle after acceptance (ADD 5,7 -> 100) -> rsp_res remains 12.
